// File: rtl/card_draw_scheduler.sv
// card_draw_scheduler: shares one deck between the player and dealer hands, runs the opening deal and arbitrates hits
module card_draw_scheduler #(
    parameter int CARD_W         = 4,
    parameter int MAX_CARDS      = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_startDeal,
    input  logic              i_clear,
    input  logic              i_playerReq,
    input  logic              i_dealerReq,
    output logic              o_deckReq,
    input  logic              i_deckValid,
    input  logic [CARD_W-1:0] i_deckCard,
    output logic [CARD_W-1:0] o_card,
    output logic              o_playerLoad,
    output logic              o_dealerLoad,
    output logic              o_playerAck,
    output logic              o_dealerAck,
    output logic [2:0]        o_playerCount,
    output logic [2:0]        o_dealerCount,
    output logic              o_busy,
    output logic              o_dealDone,
    output logic              o_error
);
    localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DELIVER} state_t;

    state_t        state, stateNext;
    logic [TW-1:0] timer;
    logic [1:0]    dealIdx;
    logic          dealMode, target, rrPtr, refAckP, refAckD;
    logic          pReq, dReq, winner, winnerFull, timedOut;
    logic          doClear, doStart, doGrant, doRefuse;

    // a refusal ack is registered, so mask that side for the ack cycle to avoid a second refusal
    assign pReq       = i_playerReq & ~refAckP;
    assign dReq       = i_dealerReq & ~refAckD;
    assign winner     = (pReq & dReq) ? rrPtr : dReq;
    assign winnerFull = winner ? (o_dealerCount == 3'(MAX_CARDS)) : (o_playerCount == 3'(MAX_CARDS));
    assign timedOut   = timer == TW'(TIMEOUT_CYCLES - 1);
    assign o_busy     = state != S_IDLE;

    // state register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= S_IDLE;
        else         state <= stateNext;
    end

    // next-state decode and strobe outputs
    always_comb begin
        stateNext    = state;
        o_deckReq    = 1'b0;
        o_playerLoad = 1'b0;
        o_dealerLoad = 1'b0;
        o_playerAck  = refAckP;
        o_dealerAck  = refAckD;
        doClear      = 1'b0;
        doStart      = 1'b0;
        doGrant      = 1'b0;
        doRefuse     = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_clear) doClear = 1'b1;
                else if (i_startDeal) begin
                    doStart   = 1'b1;
                    stateNext = S_ISSUE;
                end else if (pReq | dReq) begin
                    doRefuse  = winnerFull;
                    doGrant   = ~winnerFull;
                    stateNext = winnerFull ? S_IDLE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                o_deckReq = 1'b1;
                stateNext = S_WAIT;
            end
            S_WAIT: begin
                if (i_deckValid) stateNext = S_DELIVER;
                else if (timedOut) begin
                    o_playerAck = ~dealMode & ~target;
                    o_dealerAck = ~dealMode & target;
                    stateNext   = S_IDLE;
                end
            end
            S_DELIVER: begin
                o_playerLoad = ~target;
                o_dealerLoad = target;
                o_playerAck  = ~dealMode & ~target;
                o_dealerAck  = ~dealMode & target;
                stateNext    = (dealMode && dealIdx != 2'd3) ? S_ISSUE : S_IDLE;
            end
            default: stateNext = S_IDLE;
        endcase
    end

    // counts, card latch, deal sequencing, arbitration pointer and timeout tracking
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            timer         <= '0;
            dealIdx       <= 2'd0;
            dealMode      <= 1'b0;
            target        <= 1'b0;
            rrPtr         <= 1'b0;
            refAckP       <= 1'b0;
            refAckD       <= 1'b0;
            o_card        <= '0;
            o_playerCount <= 3'd0;
            o_dealerCount <= 3'd0;
            o_dealDone    <= 1'b0;
            o_error       <= 1'b0;
        end else begin
            o_dealDone <= state == S_DELIVER && dealMode && dealIdx == 2'd3;
            refAckP    <= doRefuse & ~winner;
            refAckD    <= doRefuse & winner;
            if (doClear) begin
                o_playerCount <= 3'd0;
                o_dealerCount <= 3'd0;
                o_error       <= 1'b0;
            end
            if (doStart) begin
                o_playerCount <= 3'd0;
                o_dealerCount <= 3'd0;
                dealMode      <= 1'b1;
                dealIdx       <= 2'd0;
                target        <= 1'b0;
            end
            if (doGrant) begin
                dealMode <= 1'b0;
                target   <= winner;
                rrPtr    <= ~winner;
            end
            if (state == S_ISSUE) timer <= '0;
            if (state == S_WAIT) begin
                if (i_deckValid) o_card <= i_deckCard;
                else if (timedOut) begin
                    o_error  <= 1'b1;
                    dealMode <= 1'b0;
                end else timer <= timer + 1'b1;
            end
            if (state == S_DELIVER) begin
                if (target) o_dealerCount <= o_dealerCount + 3'(o_dealerCount != 3'(MAX_CARDS));
                else        o_playerCount <= o_playerCount + 3'(o_playerCount != 3'(MAX_CARDS));
                if (dealMode && dealIdx != 2'd3) begin
                    dealIdx <= dealIdx + 2'd1;
                    target  <= ~target;
                end else dealMode <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_card_draw_scheduler.sv
// tb_card_draw_scheduler: directed checks of deal sequencing, arbitration, refusal, timeout and reset
module tb_card_draw_scheduler;
    logic       i_clk = 1'b0, i_reset = 1'b1, i_startDeal = 1'b0, i_clear = 1'b0;
    logic       i_playerReq = 1'b0, i_dealerReq = 1'b0, i_deckValid = 1'b0;
    logic [3:0] i_deckCard = 4'd0;
    logic [3:0] o_card;
    logic       o_deckReq, o_playerLoad, o_dealerLoad, o_playerAck, o_dealerAck;
    logic       o_busy, o_dealDone, o_error;
    logic [2:0] o_playerCount, o_dealerCount;

    int vectors = 0, miscompares = 0;
    int deckReqs = 0, pLoads = 0, dLoads = 0, pAcks = 0, dAcks = 0, dealDones = 0;
    int snapReq, snapPL, snapDL, snapPA, snapDA;

    card_draw_scheduler dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_startDeal(i_startDeal), .i_clear(i_clear),
        .i_playerReq(i_playerReq), .i_dealerReq(i_dealerReq), .o_deckReq(o_deckReq),
        .i_deckValid(i_deckValid), .i_deckCard(i_deckCard), .o_card(o_card),
        .o_playerLoad(o_playerLoad), .o_dealerLoad(o_dealerLoad),
        .o_playerAck(o_playerAck), .o_dealerAck(o_dealerAck),
        .o_playerCount(o_playerCount), .o_dealerCount(o_dealerCount),
        .o_busy(o_busy), .o_dealDone(o_dealDone), .o_error(o_error)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        deckReqs  <= deckReqs + int'(o_deckReq);
        pLoads    <= pLoads + int'(o_playerLoad);
        dLoads    <= dLoads + int'(o_dealerLoad);
        pAcks     <= pAcks + int'(o_playerAck);
        dAcks     <= dAcks + int'(o_dealerAck);
        dealDones <= dealDones + int'(o_dealDone);
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic snap();
        snapReq = deckReqs; snapPL = pLoads; snapDL = dLoads; snapPA = pAcks; snapDA = dAcks;
    endtask

    // enters in S_ISSUE, deck answers two cycles after the request, leaves after S_DELIVER
    task automatic serve(input logic [3:0] c, input logic toPlayer, input logic ack);
        check("deckReq", int'(o_deckReq), 1);
        tick();
        tick();
        i_deckValid = 1'b1;
        i_deckCard  = c;
        tick();
        i_deckValid = 1'b0;
        check("playerLoad", int'(o_playerLoad), int'(toPlayer));
        check("dealerLoad", int'(o_dealerLoad), int'(!toPlayer));
        check("card", int'(o_card), int'(c));
        check("playerAck", int'(o_playerAck), int'(ack & toPlayer));
        check("dealerAck", int'(o_dealerAck), int'(ack & !toPlayer));
        if (ack && toPlayer) i_playerReq = 1'b0;
        if (ack && !toPlayer) i_dealerReq = 1'b0;
        tick();
    endtask

    initial begin
        tick();
        tick();
        i_reset = 1'b0;
        check("rst busy", int'(o_busy), 0);
        check("rst pCount", int'(o_playerCount), 0);
        check("rst dCount", int'(o_dealerCount), 0);
        check("rst card", int'(o_card), 0);
        check("rst error", int'(o_error), 0);
        check("rst deckReq", int'(o_deckReq), 0);
        tick();

        snap();
        i_startDeal = 1'b1;
        tick();
        i_startDeal = 1'b0;
        check("deal busy", int'(o_busy), 1);
        serve(4'd3, 1'b1, 1'b0);
        serve(4'd9, 1'b0, 1'b0);
        serve(4'd5, 1'b1, 1'b0);
        serve(4'd10, 1'b0, 1'b0);
        check("dealDone", int'(o_dealDone), 1);
        check("deal pCount", int'(o_playerCount), 2);
        check("deal dCount", int'(o_dealerCount), 2);
        check("deal idle", int'(o_busy), 0);
        tick();
        check("dealDone drop", int'(o_dealDone), 0);
        check("deal deckReqs", deckReqs - snapReq, 4);
        check("deal dealDones", dealDones, 1);
        check("deal acks", (pAcks - snapPA) + (dAcks - snapDA), 0);

        snap();
        i_playerReq = 1'b1;
        i_dealerReq = 1'b1;
        tick();
        serve(4'd7, 1'b1, 1'b1);
        check("rr still req", int'(i_dealerReq), 1);
        tick();
        serve(4'd12, 1'b0, 1'b1);
        check("rr pCount", int'(o_playerCount), 3);
        check("rr dCount", int'(o_dealerCount), 3);
        check("rr deckReqs", deckReqs - snapReq, 2);
        check("rr pAcks", pAcks - snapPA, 1);
        check("rr dAcks", dAcks - snapDA, 1);

        i_playerReq = 1'b1;
        tick();
        serve(4'd1, 1'b1, 1'b1);
        i_playerReq = 1'b1;
        tick();
        serve(4'd2, 1'b1, 1'b1);
        check("fill pCount", int'(o_playerCount), 5);

        snap();
        i_playerReq = 1'b1;
        tick();
        check("full ack", int'(o_playerAck), 1);
        check("full deckReq", int'(o_deckReq), 0);
        check("full busy", int'(o_busy), 0);
        i_playerReq = 1'b0;
        tick();
        check("full ack drop", int'(o_playerAck), 0);
        tick();
        check("full pCount", int'(o_playerCount), 5);
        check("full deckReqs", deckReqs - snapReq, 0);
        check("full loads", (pLoads - snapPL) + (dLoads - snapDL), 0);
        check("full pAcks", pAcks - snapPA, 1);

        snap();
        i_dealerReq = 1'b1;
        tick();
        check("to deckReq", int'(o_deckReq), 1);
        tick();
        for (int i = 0; i < 15; i++) tick();
        check("to dAck", int'(o_dealerAck), 1);
        check("to err early", int'(o_error), 0);
        check("to busy", int'(o_busy), 1);
        i_dealerReq = 1'b0;
        tick();
        check("to error", int'(o_error), 1);
        check("to idle", int'(o_busy), 0);
        check("to pCount", int'(o_playerCount), 5);
        check("to dCount", int'(o_dealerCount), 3);
        check("to dAcks", dAcks - snapDA, 1);
        check("to loads", (pLoads - snapPL) + (dLoads - snapDL), 0);
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        check("clr error", int'(o_error), 0);
        check("clr pCount", int'(o_playerCount), 0);
        check("clr dCount", int'(o_dealerCount), 0);

        snap();
        i_deckValid = 1'b1;
        i_deckCard  = 4'd15;
        tick();
        i_deckValid = 1'b0;
        check("idleValid card", int'(o_card), 2);
        check("idleValid busy", int'(o_busy), 0);
        tick();
        check("idleValid card2", int'(o_card), 2);
        check("idleValid loads", (pLoads - snapPL) + (dLoads - snapDL), 0);

        snap();
        i_playerReq = 1'b1;
        tick();
        tick();
        tick();
        i_deckValid = 1'b1;
        i_deckCard  = 4'd6;
        i_reset     = 1'b1;
        #1;
        check("rstw busy", int'(o_busy), 0);
        check("rstw load", int'(o_playerLoad), 0);
        check("rstw card", int'(o_card), 0);
        tick();
        i_reset     = 1'b0;
        i_deckValid = 1'b0;
        i_playerReq = 1'b0;
        tick();
        tick();
        check("rstw pCount", int'(o_playerCount), 0);
        check("rstw loads", (pLoads - snapPL) + (dLoads - snapDL), 0);
        check("rstw idle", int'(o_busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/card_draw_scheduler.md
Name: card_draw_scheduler

Overview:
- Shares the single card deck between the player and dealer hand controllers.
- Sequences the opening deal in the order player, dealer, player, dealer.
- Arbitrates on-demand hit requests between the two hands.
- Removes the draw/add timing hazard: each card is latched from the deck and delivered with a one-cycle load strobe only after the deck returns it.

Parameters:
- CARD_W, 4, width of the card code.
- MAX_CARDS, 5, hand capacity; a request from a full hand is refused.
- TIMEOUT_CYCLES, 16, cycles to wait for i_deckValid before aborting.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  reset; asynchronous, active-high.
- i_startDeal  in  1  pulse; clears both counts and starts the 4-card opening deal.
- i_clear  in  1  pulse; clears both counts and the error flag (new round).
- i_playerReq  in  1  level; player requests one card, held until o_playerAck.
- i_dealerReq  in  1  level; dealer requests one card, held until o_dealerAck.
- o_deckReq  out  1  one-cycle draw request to the deck.
- i_deckValid  in  1  deck card valid.
- i_deckCard  in  CARD_W  card from the deck.
- o_card  out  CARD_W  latched card, valid while a load strobe is high.
- o_playerLoad  out  1  one-cycle strobe; player hand adds o_card.
- o_dealerLoad  out  1  one-cycle strobe; dealer hand adds o_card.
- o_playerAck  out  1  one-cycle; request serviced or refused.
- o_dealerAck  out  1  one-cycle; request serviced or refused.
- o_playerCount  out  3  cards delivered to the player.
- o_dealerCount  out  3  cards delivered to the dealer.
- o_busy  out  1  high in any state other than S_IDLE.
- o_dealDone  out  1  one-cycle pulse after the 4th opening card is delivered.
- o_error  out  1  sticky deck-timeout flag.

Behaviour:
- Reset (async, any state):
  - state S_IDLE.
  - All outputs 0, counts 0, o_card 0.
  - Round-robin pointer = player.
  - Deal index 0; timeout counter 0.
  - No card is ever delivered after reset.
- States: S_IDLE, S_ISSUE, S_WAIT, S_DELIVER.
- S_IDLE priority:
  - i_clear first: zero counts and o_error; stay in S_IDLE.
  - else i_startDeal: zero counts, deal mode, index 0, target player, go S_ISSUE.
  - else pending requests: arbitrate and go S_ISSUE.
  - i_startDeal and i_clear are ignored outside S_IDLE.
- Arbitration:
  - Only one request pending: it wins.
  - Both pending: the round-robin pointer's side wins; after service the pointer moves to the other side.
- Full hand: a request from a hand whose count == MAX_CARDS gets an ack pulse in S_IDLE with no load and no deck request; state stays S_IDLE.
- S_ISSUE: o_deckReq = 1 for exactly one cycle, timeout counter cleared, go S_WAIT.
- S_WAIT:
  - i_deckValid high: latch i_deckCard into o_card, go S_DELIVER.
  - Counter reaches TIMEOUT_CYCLES-1 without valid: set o_error, pulse the requester's ack (on-demand mode only), go S_IDLE, counts unchanged.
  - i_deckValid is ignored in every state except S_WAIT.
- S_DELIVER:
  - Target load strobe = 1 with o_card stable.
  - Target count increments on exit.
  - On-demand mode: target ack = 1 in the same cycle, then S_IDLE.
  - Deal mode, index < 3: index++, target toggles, go S_ISSUE.
  - Deal mode, index == 3: o_dealDone = 1 on the following S_IDLE cycle.
- Latency: request sampled in S_IDLE at cycle N, o_deckReq at N+1; deck valid at cycle M, load and ack at M+1, count updated at M+2.
- Requests arriving during the opening deal are held by the requester and arbitrated after o_dealDone.
- Counts saturate at MAX_CARDS; they never wrap.
- o_busy = (state != S_IDLE).

Test Plan:
- Deck valid 2 cycles after each o_deckReq; pulse i_startDeal with cards 3, 9, 5, 10 -> player loads 3, dealer loads 9, player loads 5, dealer loads 10; counts 2/2; o_dealDone pulses once; exactly 4 o_deckReq pulses.
- i_playerReq and i_dealerReq both held from idle, pointer = player -> player served first, dealer second; 2 deck requests; both acks pulse once, each in its own S_DELIVER cycle.
- Player count = 5, i_playerReq high -> o_playerAck next cycle; no o_deckReq, no load; count stays 5.
- Deck never asserts valid -> o_error = 1 after 16 cycles in S_WAIT; ack pulses; counts unchanged; i_clear then returns o_error to 0.
- Assert i_reset while in S_WAIT with valid arriving the same cycle -> no load strobe; counts 0; state S_IDLE.
- i_deckValid pulsed while in S_IDLE -> ignored; o_card unchanged; no strobes.
